mipi_csi_raw10_depacker: RTL and testbench
==========================================

MIPI_CSI_RAW10_DEPACKER -- requirements
Module: mipi_csi_raw10_depacker

Interface
REQ-001 Parameter MATCH_TYPE, default 3'd3 (low 3 bits of RAW10 data type 0x2B); depacking is enabled only when packet_type_i equals this value.
REQ-002 clk_i  input  1  single clock; all logic is in this domain.
REQ-003 reset_n_i  input  1  reset, asynchronous, active-low.
REQ-004 data_valid_i  input  1  payload word valid; high for a contiguous run per long packet, from the packet decoder output_valid_o.
REQ-005 data_i  input  32  payload bytes; data_i[7:0] is the earliest byte on the wire.
REQ-006 packet_type_i  input  3  packet type from the decoder; stable while data_valid_i is high.
REQ-007 output_valid_o  output  1  output_o holds one 4-pixel group.
REQ-008 output_o  output  40  pixels: [9:0]=P0, [19:10]=P1, [29:20]=P2, [39:30]=P3.
REQ-009 error_o  output  1  one-cycle pulse: packet ended with 1..4 residual bytes.

Function
REQ-010 Byte buffer of 8 bytes plus count register cnt (0..4) holds unconsumed bytes in wire order.
REQ-011 Accepted cycle = data_valid_i high and packet_type_i == MATCH_TYPE; each appends 4 bytes behind existing ones (cnt+4, range 4..8).
REQ-012 If cnt+4 >= 5 in an accepted cycle, oldest 5 bytes form a group, the remainder shifts to buffer head, and cnt becomes cnt+4-5 (0..3); otherwise cnt becomes 4.
REQ-013 Group mapping, bytes B0..B4: Pn = {Bn, B4[2n+1:2n]} for n = 0..3.
REQ-014 output_valid_o and output_o are registered; they assert in the cycle after the accepted cycle that completed the group (latency 1).
REQ-015 Input rate is at most 4 bytes/cycle and output 5 bytes/cycle, so the buffer never overflows; no back-pressure port exists.
REQ-016 Steady state: a 5-word input window yields exactly 4 output groups; output_valid_o is low in 1 cycle of every 5 consecutive accepted cycles.
REQ-017 End of packet: data_valid_i high-to-low clears cnt to 0 in the next cycle; if cnt was non-zero, error_o pulses high for that one cycle and the residual bytes are discarded.
REQ-018 Non-matching type: while data_valid_i is high and packet_type_i != MATCH_TYPE, nothing is accepted, output_valid_o stays low and cnt stays 0.
REQ-019 output_o holds its last value while output_valid_o is low.
REQ-020 Back-to-back packets with data_valid_i low for a single cycle behave identically to packets with longer gaps.

Reset
REQ-021 When reset_n_i is low: cnt=0, buffer=0, output_valid_o=0, output_o=0, error_o=0, applied asynchronously.
REQ-022 Reset asserted mid-packet discards all buffered bytes without an error_o pulse; depacking resumes only on the next rising edge of data_valid_i.

Structure
REQ-023 Shared package mipi_csi_pkg holds the RAW10 data-type constant (0x2B), PIXEL_WIDTH=10, PIXELS_PER_GROUP=4 and BYTES_PER_GROUP=5.
REQ-024 One combinational sub-module, mipi_csi_raw10_unpack, maps 5 bytes to 4 pixels per REQ-013.

Verification
REQ-025 Header 0x2B, WC=0x0960 (2400 bytes = 600 words) -> exactly 480 output_valid_o pulses, error_o never high.
REQ-026 Words 0x44332211, 0xXXXXXX55 (B4=0x55) -> first group P0=0x045, P1=0x089, P2=0x0CD, P3=0x111 one cycle after the second word.
REQ-027 Packet of 3 words (12 bytes) -> 2 groups, then error_o pulses once one cycle after data_valid_i falls (2 residual bytes).
REQ-028 Packet with packet_type_i=3'd2, 100 words -> output_valid_o never high, error_o never high.
REQ-029 reset_n_i pulsed low after word 7 of a packet -> all outputs 0 immediately, no error_o; a following clean 5-word packet yields exactly 4 groups.
REQ-030 Two 5-word packets separated by a 1-cycle gap -> 4 groups each, correct pixel values, no cross-packet byte mixing.

Source files
------------

// File: rtl/mipi_csi_raw10_depacker_pkg.sv
// Shared constants and types for the CSI-2 RAW10 depacker.
// The RAW10 data type and the pixel-group geometry live here so every stage agrees.
package mipi_csi_pkg;

  localparam logic [7:0] RAW10_DT         = 8'h2B;
  localparam int         PIXEL_WIDTH      = 10;
  localparam int         PIXELS_PER_GROUP = 4;
  localparam int         BYTES_PER_GROUP  = 5;
  localparam int         WORD_BYTES       = 4;
  localparam int         BUF_BYTES        = 8;
  localparam int         GROUP_W          = PIXEL_WIDTH * PIXELS_PER_GROUP;

  // ST_WAIT_LOW blocks a packet that was already running when reset released.
  typedef enum logic [1:0] {
    ST_WAIT_LOW = 2'd0,
    ST_IDLE     = 2'd1,
    ST_ACTIVE   = 2'd2
  } depack_state_e;

endpackage

// File: rtl/mipi_csi_raw10_depacker_if.sv
// Payload-in / pixel-out bundle between the packet decoder, the depacker and its sink.
// data_valid_i qualifies one 32-bit word; there is no ready, every valid word is taken.
interface mipi_csi_raw10_depacker_if;
  import mipi_csi_pkg::*;

  logic               data_valid_i;
  logic [31:0]        data_i;
  logic [2:0]         packet_type_i;
  logic               output_valid_o;
  logic [GROUP_W-1:0] output_o;
  logic               error_o;

  modport master (
    output data_valid_i, data_i, packet_type_i,
    input  output_valid_o, output_o, error_o
  );

  modport slave (
    input  data_valid_i, data_i, packet_type_i,
    output output_valid_o, output_o, error_o
  );

endinterface

// File: rtl/mipi_csi_raw10_unpack.sv
// Combinational RAW10 unpack: 5 wire bytes to 4 pixels.
// Byte 4 carries the two LSBs of each pixel, pixel n taking bits [2n+1:2n].
module mipi_csi_raw10_unpack
  import mipi_csi_pkg::*;
(
  input  logic [8*BYTES_PER_GROUP-1:0] bytes_i,
  output logic [GROUP_W-1:0]           pixels_o
);

  localparam int LSB_BYTE = 8 * (BYTES_PER_GROUP - 1);

  always_comb begin
    pixels_o = '0;
    for (int n = 0; n < PIXELS_PER_GROUP; n++) begin
      pixels_o[n*PIXEL_WIDTH +: PIXEL_WIDTH] = {bytes_i[8*n +: 8], bytes_i[LSB_BYTE + 2*n +: 2]};
    end
  end

endmodule

// File: rtl/mipi_csi_raw10_depacker.sv
// RAW10 depacker: buffers payload bytes in wire order and emits one registered
// 4-pixel group whenever 5 bytes are available; flags packets ending mid-group.
module mipi_csi_raw10_depacker
  import mipi_csi_pkg::*;
#(
  parameter logic [2:0] MATCH_TYPE = RAW10_DT[2:0]
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  mipi_csi_raw10_depacker_if.slave    bus,
  output depack_state_e               dbg_state_o
);

  depack_state_e        state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [8*BUF_BYTES-1:0] buf_q, buf_d;
  logic                 out_valid_q, out_valid_d;
  logic [GROUP_W-1:0]   out_q, out_d;
  logic                 err_q, err_d;

  logic [8*BUF_BYTES-1:0] merged;
  logic [GROUP_W-1:0]   pixels;
  logic                 accept;
  logic                 group_done;
  int                   cnt_int;
  int                   total;

  mipi_csi_raw10_unpack u_unpack (
    .bytes_i  (merged[8*BYTES_PER_GROUP-1:0]),
    .pixels_o (pixels)
  );

  // Append the incoming word right behind the bytes still waiting in the buffer.
  always_comb begin
    merged  = '0;
    cnt_int = int'(cnt_q);
    for (int i = 0; i < BUF_BYTES; i++) begin
      if (i < cnt_int) begin
        merged[8*i +: 8] = buf_q[8*i +: 8];
      end else if (i < cnt_int + WORD_BYTES) begin
        merged[8*i +: 8] = bus.data_i[8*(i-cnt_int) +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    out_valid_d = 1'b0;
    out_d       = out_q;
    err_d       = 1'b0;
    total       = int'(cnt_q) + WORD_BYTES;

    accept     = bus.data_valid_i && (bus.packet_type_i == MATCH_TYPE) &&
                 (state_q != ST_WAIT_LOW);
    group_done = accept && (total >= BYTES_PER_GROUP);

    unique case (state_q)
      ST_WAIT_LOW: if (!bus.data_valid_i) state_d = ST_IDLE;
      ST_IDLE:     if (bus.data_valid_i)  state_d = ST_ACTIVE;
      ST_ACTIVE:   if (!bus.data_valid_i) state_d = ST_IDLE;
      default:     state_d = ST_WAIT_LOW;
    endcase

    if (group_done) begin
      out_valid_d = 1'b1;
      out_d       = pixels;
      buf_d       = merged >> (8 * BYTES_PER_GROUP);
      cnt_d       = 3'(total - BYTES_PER_GROUP);
    end else if (accept) begin
      buf_d = merged;
      cnt_d = 3'(WORD_BYTES);
    end

    // Leftover bytes never survive a gap, so packets cannot bleed into each other.
    if (!bus.data_valid_i) begin
      cnt_d = '0;
      buf_d = '0;
      err_d = (state_q == ST_ACTIVE) && (cnt_q != 3'd0);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_WAIT_LOW;
      cnt_q       <= '0;
      buf_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      err_q       <= err_d;
    end
  end

  assign bus.output_valid_o = out_valid_q;
  assign bus.output_o       = out_q;
  assign bus.error_o        = err_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_mipi_csi_raw10_depacker.sv
// Directed bench for the RAW10 depacker: hand-computed groups, packet-end
// error pulses, type filtering, mid-packet reset and back-to-back packets.
module tb_mipi_csi_raw10_depacker;
  import mipi_csi_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mipi_csi_raw10_depacker_if bus();
  depack_state_e dbg_state;

  mipi_csi_raw10_depacker #(.MATCH_TYPE(3'd3)) dut (
    .clk_i       (clk),
    .reset_n_i   (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int vld_cnt  = 0;
  int err_cnt  = 0;
  bit sb_en    = 1'b0;
  logic [39:0] exp_q[$];

  localparam logic [39:0] G_A = {10'h111, 10'h0CD, 10'h089, 10'h045};
  localparam logic [39:0] G_B = {10'h004, 10'h2A8, 10'h2EC, 10'h332};
  localparam logic [39:0] G_S0 = {10'h010, 10'h00C, 10'h009, 10'h005};
  localparam logic [39:0] G_S1 = {10'h024, 10'h020, 10'h01E, 10'h01A};
  localparam logic [39:0] G_S2 = {10'h038, 10'h034, 10'h033, 10'h02F};
  localparam logic [39:0] G_S3 = {10'h04C, 10'h049, 10'h045, 10'h040};

  logic [31:0] seq_w[5] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09,
                            32'h100F0E0D, 32'h14131211};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic [2:0] t);
    bus.data_valid_i  = 1'b1;
    bus.data_i        = w;
    bus.packet_type_i = t;
    step();
  endtask

  task automatic idle(input int n);
    bus.data_valid_i = 1'b0;
    step(n);
  endtask

  task automatic push_seq_groups();
    exp_q.push_back(G_S0);
    exp_q.push_back(G_S1);
    exp_q.push_back(G_S2);
    exp_q.push_back(G_S3);
  endtask

  // Pulse counters and the group scoreboard sample on the falling edge.
  always @(negedge clk) begin
    logic [39:0] e;
    if (bus.output_valid_o) vld_cnt++;
    if (bus.error_o) err_cnt++;
    if (sb_en && bus.output_valid_o) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 40'hx;
      chk("sb_group", 64'(bus.output_o), 64'(e));
    end
  end

  initial begin
    bus.data_valid_i  = 1'b0;
    bus.data_i        = '0;
    bus.packet_type_i = 3'd3;

    // reset state
    #12;
    chk("rst_valid", 64'(bus.output_valid_o), 64'd0);
    chk("rst_output", 64'(bus.output_o), 64'd0);
    chk("rst_error", 64'(bus.error_o), 64'd0);
    step();
    rst_n = 1'b1;
    step(2);
    chk("state_idle", 64'(dbg_state), 64'(ST_IDLE));

    // first groups and 3-word packet with 2 residual bytes
    vld_cnt = 0; err_cnt = 0;
    send(32'h44332211, 3'd3);
    chk("w1_no_group", 64'(bus.output_valid_o), 64'd0);
    send(32'hAABBCC55, 3'd3);
    chk("w2_valid", 64'(bus.output_valid_o), 64'd1);
    chk("w2_group", 64'(bus.output_o), 64'(G_A));
    send(32'h04030201, 3'd3);
    chk("w3_valid", 64'(bus.output_valid_o), 64'd1);
    chk("w3_group", 64'(bus.output_o), 64'(G_B));
    idle(1);
    chk("eop_error", 64'(bus.error_o), 64'd1);
    chk("eop_valid_low", 64'(bus.output_valid_o), 64'd0);
    chk("eop_hold", 64'(bus.output_o), 64'(G_B));
    step();
    chk("eop_error_once", 64'(bus.error_o), 64'd0);
    chk("p3_groups", 64'(vld_cnt), 64'd2);
    chk("p3_errors", 64'(err_cnt), 64'd1);

    // non-matching packet type
    idle(2);
    vld_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 100; i++) send($urandom, 3'd2);
    idle(2);
    chk("type2_groups", 64'(vld_cnt), 64'd0);
    chk("type2_errors", 64'(err_cnt), 64'd0);
    chk("type2_hold", 64'(bus.output_o), 64'(G_B));

    // full 2400-byte line
    vld_cnt = 0; err_cnt = 0;
    for (int i = 0; i < 600; i++) send($urandom, 3'd3);
    idle(2);
    chk("line_groups", 64'(vld_cnt), 64'd480);
    chk("line_errors", 64'(err_cnt), 64'd0);

    // two 5-word packets, one idle cycle apart
    vld_cnt = 0; err_cnt = 0;
    sb_en = 1'b1;
    push_seq_groups();
    push_seq_groups();
    for (int i = 0; i < 5; i++) send(seq_w[i], 3'd3);
    idle(1);
    for (int i = 0; i < 5; i++) send(seq_w[i], 3'd3);
    idle(2);
    sb_en = 1'b0;
    chk("b2b_drained", 64'(exp_q.size()), 64'd0);
    chk("b2b_groups", 64'(vld_cnt), 64'd8);
    chk("b2b_errors", 64'(err_cnt), 64'd0);

    // reset in the middle of a packet
    for (int i = 0; i < 7; i++) send($urandom, 3'd3);
    chk("pre_rst_valid", 64'(bus.output_valid_o), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.output_valid_o), 64'd0);
    chk("mid_rst_output", 64'(bus.output_o), 64'd0);
    chk("mid_rst_error", 64'(bus.error_o), 64'd0);
    step();
    rst_n = 1'b1;
    vld_cnt = 0; err_cnt = 0;
    send($urandom, 3'd3);
    send($urandom, 3'd3);
    chk("post_rst_blocked", 64'(vld_cnt), 64'd0);
    chk("post_rst_state", 64'(dbg_state), 64'(ST_WAIT_LOW));
    idle(2);
    sb_en = 1'b1;
    push_seq_groups();
    for (int i = 0; i < 5; i++) send(seq_w[i], 3'd3);
    idle(2);
    sb_en = 1'b0;
    chk("post_rst_groups", 64'(vld_cnt), 64'd4);
    chk("post_rst_errors", 64'(err_cnt), 64'd0);
    chk("post_rst_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
